// File: rtl/multi_timer.sv
// multi_timer: N-channel programmable interval timer with a shared clock prescaler.
// Each channel counts down from period-1 once per prescaler tick and runs either
// periodically (auto-reload) or one-shot (stops and raises done).
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      asynchronous reset, active-high
//   period_i   per-channel period in ticks, channel i at [i*WIDTH +: WIDTH]
//   en_i       per-channel enable (level); a registered 0->1 edge starts the channel
//   mode_i     per-channel mode, 0 = periodic, 1 = one-shot; latched at every load
//   restart_i  per-channel 1-clk pulse: reload from period_i (ignored while en_i is low)
//   flag_o     registered 1-clk pulse at the end of each period
//   done_o     one-shot finished; held until en_i drops or restart_i
//   count_o    current down-counter value per channel
module multi_timer #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS*WIDTH-1:0] period_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       mode_i,
  input  logic [CHANNELS-1:0]       restart_i,
  output logic [CHANNELS-1:0]       flag_o,
  output logic [CHANNELS-1:0]       done_o,
  output logic [CHANNELS*WIDTH-1:0] count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Prescaler: free-running from reset and never cleared by channel activity,
  // so all channels share the same tick phase. PRESCALE=1 degenerates to a
  // 1-bit counter stuck at 0, which makes tick permanently high.
  localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          tick;

  assign tick      = (pre_cnt_q == PRE_LAST);
  assign pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // Previous-cycle enable, used to detect the start edge.
  logic [CHANNELS-1:0] en_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q <= '0;
    end else begin
      en_q <= en_i;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               mode_q, mode_d;
    logic               flag_q, flag_d;
    logic [WIDTH-1:0]   per;
    logic [WIDTH-1:0]   per_m1;
    logic               per_zero;
    logic               load;

    assign per      = period_i[g*WIDTH +: WIDTH];
    assign per_zero = (per == '0);
    assign per_m1   = per - WIDTH'(1);
    // Start edge or restart both load the channel; only acted on while en_i is high.
    assign load     = (en_i[g] & ~en_q[g]) | restart_i[g];

    // Priority: disable > load (restart beats a coincident expiry) > tick.
    always_comb begin
      state_d = state_q;
      count_d = count_q;
      mode_d  = mode_q;
      flag_d  = 1'b0;
      if (!en_i[g]) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else if (load) begin
        if (per_zero) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          state_d = ST_RUN;
          count_d = per_m1;
          mode_d  = mode_i[g];
        end
      end else if (state_q == ST_RUN && tick) begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else if (mode_q) begin
          flag_d  = 1'b1;
          state_d = ST_DONE;
          count_d = '0;
        end else if (per_zero) begin
          // Periodic reload with a zero period parks the channel silently.
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          flag_d  = 1'b1;
          count_d = per_m1;
          mode_d  = mode_i[g];
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        mode_q  <= 1'b0;
        flag_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        mode_q  <= mode_d;
        flag_q  <= flag_d;
      end
    end

    assign flag_o[g]                  = flag_q;
    assign done_o[g]                  = (state_q == ST_DONE);
    assign count_o[g*WIDTH +: WIDTH]  = count_q;
  end

endmodule

// File: tb/tb_multi_timer.sv
// Testbench for multi_timer: two instances (PRESCALE=1 and PRESCALE=4) share
// one set of inputs; a ticks-remaining reference model predicts their outputs,
// expectations are queued per clock and a monitor compares after each edge.
module tb_multi_timer;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int NI = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] period;
  logic [CH-1:0]   en, mode, restart;
  logic [CH-1:0]   flag1, done1, flag4, done4;
  logic [CH*W-1:0] count1, count4;

  always #5 clk = ~clk;

  multi_timer #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .period_i(period), .en_i(en), .mode_i(mode),
    .restart_i(restart), .flag_o(flag1), .done_o(done1), .count_o(count1)
  );

  multi_timer #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .period_i(period), .en_i(en), .mode_i(mode),
    .restart_i(restart), .flag_o(flag4), .done_o(done4), .count_o(count4)
  );

  typedef struct packed {
    logic [CH-1:0]   flag;
    logic [CH-1:0]   done;
    logic [CH*W-1:0] count;
  } obs_t;

  typedef struct packed {
    obs_t p1;
    obs_t p4;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_cyc  = 0;

  // Reference model: per instance/channel, whether it is counting, its latched
  // mode, the done status and the number of ticks left until the period ends.
  bit m_act [NI][CH];
  bit m_osh [NI][CH];
  bit m_fin [NI][CH];
  int m_rem [NI][CH];
  bit m_enp [CH];
  int m_cyc;

  task automatic model_reset();
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < CH; c++) begin
        m_act[i][c] = 0; m_osh[i][c] = 0; m_fin[i][c] = 0; m_rem[i][c] = 0;
      end
    for (int c = 0; c < CH; c++) m_enp[c] = 0;
    m_cyc = 0;
  endtask

  // Advance the model over the coming clock edge using the inputs now applied.
  task automatic model_step();
    exp_t e;
    obs_t o;
    e = '0;
    for (int i = 0; i < NI; i++) begin
      int pre;
      bit tk;
      pre = (i == 0) ? 1 : 4;
      tk  = (m_cyc % pre) == pre - 1;
      o   = '0;
      for (int c = 0; c < CH; c++) begin
        int p;
        bit st;
        p  = int'(period[c*W +: W]);
        st = en[c] && !m_enp[c];
        if (!en[c]) begin
          m_act[i][c] = 0;
          m_fin[i][c] = 0;
        end else if (st || restart[c]) begin
          m_fin[i][c] = 0;
          m_act[i][c] = (p != 0);
          m_osh[i][c] = mode[c];
          m_rem[i][c] = p;
        end else if (m_act[i][c] && tk) begin
          if (m_rem[i][c] > 1) begin
            m_rem[i][c] = m_rem[i][c] - 1;
          end else if (m_osh[i][c]) begin
            o.flag[c]   = 1'b1;
            m_act[i][c] = 0;
            m_fin[i][c] = 1;
          end else if (p == 0) begin
            m_act[i][c] = 0;
          end else begin
            o.flag[c]   = 1'b1;
            m_rem[i][c] = p;
            m_osh[i][c] = mode[c];
          end
        end
        o.done[c] = m_fin[i][c];
        o.count[c*W +: W] = m_act[i][c] ? W'(m_rem[i][c] - 1) : '0;
      end
      if (i == 0) e.p1 = o;
      else        e.p4 = o;
    end
    for (int c = 0; c < CH; c++) m_enp[c] = en[c];
    m_cyc++;
    exp_q.push_back(e);
  endtask

  // Called just after a negedge: record expectation, pass one clock, end restart pulses.
  task automatic adv(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(negedge clk);
      restart = '0;
    end
  endtask

  task automatic set_per(input int c, input int v);
    period[c*W +: W] = W'(v);
  endtask

  task automatic chk_reset(input string tag);
    checks++;
    if ({flag1, done1, count1, flag4, done4, count4} !== '0) begin
      failures++;
      $display("FAIL %s got flag1=%h done1=%h count1=%h flag4=%h done4=%h count4=%h, required all zero",
               tag, flag1, done1, count1, flag4, done4, count4);
    end
  endtask

  // Monitor: compare both instances against the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        mon_cyc++;
        checks++;
        if ({flag1, done1, count1} !== e.p1) begin
          failures++;
          $display("FAIL pre1 cyc=%0d got flag=%h done=%h count=%h required flag=%h done=%h count=%h",
                   mon_cyc, flag1, done1, count1, e.p1.flag, e.p1.done, e.p1.count);
        end
        checks++;
        if ({flag4, done4, count4} !== e.p4) begin
          failures++;
          $display("FAIL pre4 cyc=%0d got flag=%h done=%h count=%h required flag=%h done=%h count=%h",
                   mon_cyc, flag4, done4, count4, e.p4.flag, e.p4.done, e.p4.count);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rst = 1'b1; period = '0; en = '0; mode = '0; restart = '0;
    model_reset();
    #1;
    chk_reset("reset_state");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    adv(3);

    // ch0 periodic, period 2
    set_per(0, 2); en[0] = 1'b1;
    adv(9);
    // period change mid-count: takes effect at next reload
    set_per(0, 3);
    adv(12);

    // ch1 one-shot, period 5; drop en, re-raise
    set_per(1, 5); mode[1] = 1'b1; en[1] = 1'b1;
    adv(8);
    en[1] = 1'b0;
    adv(2);
    en[1] = 1'b1;
    adv(8);
    // restart out of DONE
    restart[1] = 1'b1;
    adv(7);

    // restart coinciding with ch0 expiry
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (m_act[0][0] && m_rem[0][0] == 1) begin
        restart[0] = 1'b1;
        hit = 1;
      end
      adv();
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL restart_on_expiry got no expiry slot found, required slot within 20 clks");
    end
    adv(6);

    // restart with en low is ignored
    restart[3] = 1'b1;
    adv(3);

    // ch2 period 3: steady flags every 12 clks on the PRESCALE=4 instance
    set_per(2, 3); en[2] = 1'b1;
    adv(40);
    set_per(2, 0);
    adv(20);
    restart[2] = 1'b1;
    adv(4);

    // async reset mid-count on all channels
    for (int c = 0; c < CH; c++) set_per(c, 5);
    mode = '0; en = '0;
    adv();
    en = '1;
    adv(3);
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    en = '0;
    #1;
    rst = 1'b0;
    model_reset();
    adv(6);
    en = '1;
    adv(12);

    // randomized traffic
    for (int k = 0; k < 2500; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 29) == 0) restart[c] = 1'b1;
        if ($urandom_range(0, 49) == 0) set_per(c, $urandom_range(0, 7));
        if ($urandom_range(0, 49) == 0) mode[c] = ~mode[c];
      end
      adv();
    end

    // maximum period on ch3
    en = '0; mode = '0;
    adv();
    set_per(3, 255); en[3] = 1'b1;
    adv(260);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
